// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   IF stage of a 5-stage pipeline. Owns the PC, drives the instruction
//   memory and loads the IF/ID pipeline register. A taken redirect from ID
//   squashes the instruction fetched behind it (no delay slot). If the i-mem
//   access is still outstanding when a redirect arrives, the stage enters
//   DRAIN, lets the wrong-path access finish, throws its data away and only
//   then jumps to the saved target.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   stall          hazard stall: freeze PC and IF/ID
//   PCSrc[1:0]     00 sequential, 01 branch, 10 j/jal, 11 jr/jalr
//   BranchTarget   redirect target for PCSrc=01
//   JumpTarget     redirect target for PCSrc=10
//   RegTarget      forwarded rs value for PCSrc=11
//   imem_req       fetch request, high whenever not in reset
//   imem_addr      fetch address (the PC)
//   imem_rdata     instruction word, valid while imem_ready=1
//   imem_ready     access completes this cycle
//   IF_ID_Instr    instruction to ID (0 = bubble)
//   IF_ID_PCPlus4  PC+4 of IF_ID_Instr
//   IF_ID_Valid    IF_ID_Instr is a real instruction
//   fetch_busy     draining, or a request is waiting on the memory
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] RegTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        fetch_busy
);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] saved_tgt, saved_tgt_next;
    logic [31:0] instr_next, pcplus4_next;
    logic        valid_next;
    logic [31:0] redirect_raw, redirect_tgt, pc_plus4;

    assign pc_plus4     = pc + 32'd4;   // wraps modulo 2^32
    assign redirect_tgt = {redirect_raw[31:2], 2'b00};

    assign imem_req   = ~reset;
    // The PC only moves on a completed access, so the address is stable
    // for the whole life of an outstanding request.
    assign imem_addr  = pc;
    assign fetch_busy = (state == DRAIN) | (imem_req & ~imem_ready);

    always_comb begin
        redirect_raw = 32'h0;
        unique case (PCSrc)
            2'b01:   redirect_raw = BranchTarget;
            2'b10:   redirect_raw = JumpTarget;
            2'b11:   redirect_raw = RegTarget;
            default: redirect_raw = 32'h0;
        endcase
    end

    always_comb begin
        // NOTE: every combinational output gets a hold value first, so no
        // path through the case below can infer a latch.
        state_next     = state;
        pc_next        = pc;
        saved_tgt_next = saved_tgt;
        instr_next     = IF_ID_Instr;
        pcplus4_next   = IF_ID_PCPlus4;
        valid_next     = IF_ID_Valid;

        unique case (state)
            FETCH: begin
                // A stall freezes everything; returned data is dropped and
                // the same PC is fetched again once the stall clears.
                if (!stall) begin
                    if (PCSrc != 2'b00) begin
                        instr_next = 32'h0;
                        valid_next = 1'b0;
                        if (imem_ready) begin
                            pc_next = redirect_tgt;
                        end else begin
                            saved_tgt_next = redirect_tgt;
                            state_next     = DRAIN;
                        end
                    end else if (imem_ready) begin
                        instr_next   = imem_rdata;
                        pcplus4_next = pc_plus4;
                        valid_next   = 1'b1;
                        pc_next      = pc_plus4;
                    end else begin
                        instr_next = 32'h0;
                        valid_next = 1'b0;
                    end
                end
            end
            DRAIN: begin
                // The wrong-path access completes regardless of stall;
                // a stall only protects the IF/ID register.
                if (!stall) begin
                    instr_next = 32'h0;
                    valid_next = 1'b0;
                end
                if (imem_ready) begin
                    pc_next    = saved_tgt;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            saved_tgt     <= 32'h0;
            IF_ID_Instr   <= 32'h0;
            IF_ID_PCPlus4 <= 32'h0;
            IF_ID_Valid   <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            saved_tgt     <= saved_tgt_next;
            IF_ID_Instr   <= instr_next;
            IF_ID_PCPlus4 <= pcplus4_next;
            IF_ID_Valid   <= valid_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A driver applies one set of inputs
//   per cycle, steps a behavioural model of the fetch stage and pushes the
//   outputs the DUT must show during that cycle into a scoreboard queue. A
//   monitor on the falling edge pops and compares. Directed sequences from
//   the stage's usage scenarios are followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, imem_ready;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget, JumpTarget, RegTarget, imem_rdata;
    logic        imem_req, IF_ID_Valid, fetch_busy;
    logic [31:0] imem_addr, IF_ID_Instr, IF_ID_PCPlus4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .PCSrc         (PCSrc),
        .BranchTarget  (BranchTarget),
        .JumpTarget    (JumpTarget),
        .RegTarget     (RegTarget),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
        .IF_ID_Valid   (IF_ID_Valid),
        .fetch_busy    (fetch_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [31:0] addr, instr, pcp4;
        logic        valid, busy, req;
    } exp_t;

    exp_t        sb[$];
    bit          m_known = 0;      // model state defined once a reset was seen
    bit          m_draining = 0;   // a wrong-path access is still in flight
    logic [31:0] m_pc = '0, m_saved = '0, m_instr = '0, m_pcp4 = '0;
    logic        m_valid = 1'b0;

    function automatic logic [31:0] target_of(input logic [1:0] src, input logic [31:0] bt,
                                              input logic [31:0] jt, input logic [31:0] rt);
        logic [31:0] t;
        t = (src == 2'd1) ? bt : (src == 2'd2) ? jt : rt;
        return t & 32'hFFFF_FFFC;
    endfunction

    // One clock cycle: apply inputs, record what the DUT must show during
    // this cycle, then advance the model across the coming rising edge.
    task automatic step(input logic r, input logic s, input logic [1:0] src,
                        input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] rt,
                        input logic rdy, input logic [31:0] rd);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; stall = s; PCSrc = src;
        BranchTarget = bt; JumpTarget = jt; RegTarget = rt;
        imem_ready = rdy; imem_rdata = rd;
        if (m_known) begin
            e.due   = cyc;
            e.addr  = m_pc;
            e.instr = m_instr;
            e.pcp4  = m_pcp4;
            e.valid = m_valid;
            e.req   = !r;
            e.busy  = m_draining || (!r && !rdy);
            sb.push_back(e);
        end
        if (r) begin
            m_known = 1; m_draining = 0; m_pc = RESET_PC; m_saved = '0;
            m_instr = '0; m_pcp4 = '0; m_valid = 0;
        end else if (m_draining) begin
            if (!s) begin m_instr = '0; m_valid = 0; end
            if (rdy) begin m_pc = m_saved; m_draining = 0; end
        end else if (s) begin
            // stalled: nothing moves
        end else if (src != 2'd0) begin
            m_instr = '0; m_valid = 0;
            if (rdy) m_pc = target_of(src, bt, jt, rt);
            else begin m_saved = target_of(src, bt, jt, rt); m_draining = 1; end
        end else if (rdy) begin
            m_instr = rd; m_pcp4 = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
        end else begin
            m_instr = '0; m_valid = 0;
        end
    endtask

    // Directed helper: one target value routed to the selected source, junk
    // on the other two so a wrong mux select shows up.
    task automatic go(input logic r, input logic s, input logic [1:0] src, input logic [31:0] tgt,
                      input logic rdy, input logic [31:0] rd);
        step(r, s, src,
             (src == 2'd1) ? tgt : 32'hDEAD_0100,
             (src == 2'd2) ? tgt : 32'hDEAD_0200,
             (src == 2'd3) ? tgt : 32'hDEAD_0300,
             rdy, rd);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check("sb_addr",  imem_addr,     mon_e.addr);
            check("sb_instr", IF_ID_Instr,   mon_e.instr);
            check("sb_pcp4",  IF_ID_PCPlus4, mon_e.pcp4);
            check("sb_valid", 32'(IF_ID_Valid), 32'(mon_e.valid));
            check("sb_busy",  32'(fetch_busy),  32'(mon_e.busy));
            check("sb_req",   32'(imem_req),    32'(mon_e.req));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1; stall = 0; PCSrc = 0; BranchTarget = 0; JumpTarget = 0;
        RegTarget = 0; imem_ready = 0; imem_rdata = 0;

        // Reset, then straight-line fetch with rdata = addr|1
        go(1, 0, 2'd0, 0, 1, 32'h0);
        go(1, 0, 2'd0, 0, 1, 32'h0);
        go(0, 0, 2'd0, 0, 1, 32'h1);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", 32'(IF_ID_Valid), 32'h0);
        go(0, 0, 2'd0, 0, 1, 32'h5);
        check("seq_pcp4_4", IF_ID_PCPlus4, 32'h4);
        check("seq_instr_1", IF_ID_Instr, 32'h1);
        // Stall at PC=8 for two cycles
        go(0, 1, 2'd0, 0, 1, 32'hAAAA_AAAA);
        check("seq_pc_8", imem_addr, 32'h8);
        go(0, 1, 2'd0, 0, 1, 32'hBBBB_BBBB);
        go(0, 0, 2'd0, 0, 1, 32'h9);
        check("stall_pc", imem_addr, 32'h8);
        check("stall_pcp4", IF_ID_PCPlus4, 32'h8);
        // Branch to 0x43 (low bits forced to 00)
        go(0, 0, 2'd1, 32'h43, 1, 32'hCCCC_CCCC);
        check("resume_pcp4", IF_ID_PCPlus4, 32'hC);
        check("resume_instr", IF_ID_Instr, 32'h9);
        go(0, 0, 2'd0, 0, 1, 32'h41);
        check("br_pc", imem_addr, 32'h40);
        check("br_bubble", IF_ID_Instr, 32'h0);
        check("br_bubble_pcp4", IF_ID_PCPlus4, 32'hC);
        go(0, 0, 2'd2, 32'h10, 1, 32'h45);
        check("br_next_pcp4", IF_ID_PCPlus4, 32'h44);
        // jr to 0x80 with the access outstanding for three cycles
        go(0, 0, 2'd3, 32'h80, 0, 32'hEEEE_EEEE);
        check("jr_pc", imem_addr, 32'h10);
        go(0, 0, 2'd2, 32'h300, 0, 32'hEEEE_EEEE);
        check("drain_addr", imem_addr, 32'h10);
        check("drain_busy", 32'(fetch_busy), 32'h1);
        go(0, 0, 2'd0, 0, 0, 32'hEEEE_EEEE);
        go(0, 0, 2'd0, 0, 1, 32'hBAD0_0001);
        go(0, 0, 2'd0, 0, 1, 32'h81);
        check("drain_pc", imem_addr, 32'h80);
        check("drain_discard", IF_ID_Instr, 32'h0);
        // Stall and jump in the same cycle
        go(0, 1, 2'd2, 32'h200, 1, 32'h85);
        check("pre_sj_pc", imem_addr, 32'h84);
        go(0, 0, 2'd0, 0, 1, 32'h85);
        check("sj_pc", imem_addr, 32'h84);
        check("sj_instr", IF_ID_Instr, 32'h81);
        // PC wrap, then reset during DRAIN
        go(0, 0, 2'd2, 32'hFFFF_FFFC, 1, 32'h89);
        go(0, 0, 2'd0, 0, 1, 32'h1234);
        check("wrap_pc_top", imem_addr, 32'hFFFF_FFFC);
        go(0, 0, 2'd1, 32'h600, 0, 32'h0);
        check("wrap_pc", imem_addr, 32'h0);
        check("wrap_pcp4", IF_ID_PCPlus4, 32'h0);
        go(1, 0, 2'd0, 0, 0, 32'h0);
        check("rst_in_drain_busy", 32'(fetch_busy), 32'h1);
        go(0, 0, 2'd0, 0, 1, 32'h11);
        check("rst_drain_pc", imem_addr, RESET_PC);
        check("rst_drain_busy", 32'(fetch_busy), 32'h0);
        go(0, 0, 2'd0, 0, 1, 32'h15);
        check("rst_drain_no_tgt", imem_addr, RESET_PC + 32'd4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       r, s, rdy;
            logic [1:0] src;
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 3) == 0);
            src = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'd0;
            rdy = ($urandom_range(0, 9) < 6);
            step(r, s, src, $urandom, $urandom, $urandom, rdy, $urandom);
        end

        @(negedge clk);
        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
